// File: rtl/descrambler_seq_pkg.sv
// Shared constants, block classes and helpers for the descrambler sequencer.
// Symbol values cover the 8b/10b K-codes and the 128b/130b ordered-set identifiers.
package descrambler_seq_pkg;

  localparam logic [7:0] SYM_COM    = 8'hBC;
  localparam logic [7:0] SYM_SKP_K  = 8'h1C;
  localparam logic [7:0] SYM_EIEOS  = 8'h00;
  localparam logic [7:0] SYM_SKP_OS = 8'hAA;
  localparam logic [7:0] SYM_EIOS   = 8'h66;
  localparam logic [7:0] SYM_TS1    = 8'h1E;
  localparam logic [7:0] SYM_TS2    = 8'h2D;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_OS   = 2'b10;

  localparam int unsigned BLOCK_SYMBOLS = 16;

  typedef enum logic [2:0] {
    DATA     = 3'd0,
    TS       = 3'd1,
    SKP      = 3'd2,
    EIEOS    = 3'd3,
    EIOS     = 3'd4,
    OS_OTHER = 3'd5,
    INVALID  = 3'd6
  } block_type_t;

  typedef enum logic {
    BLK_START = 1'b0,
    IN_BLOCK  = 1'b1
  } blk_state_t;

  // Zero means the width is unsupported and the sequencer must stay idle.
  function automatic logic [2:0] symbols_per_beat(input logic [5:0] width);
    case (width)
      6'd8:    return 3'd1;
      6'd16:   return 3'd2;
      6'd32:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic block_type_t classify(input logic [1:0] hdr, input logic [7:0] sym);
    block_type_t t;
    t = INVALID;
    if (hdr == SYNC_DATA) begin
      t = DATA;
    end else if (hdr == SYNC_OS) begin
      case (sym)
        SYM_EIEOS:        t = EIEOS;
        SYM_SKP_OS:       t = SKP;
        SYM_EIOS:         t = EIOS;
        SYM_TS1, SYM_TS2: t = TS;
        default:          t = OS_OTHER;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/descrambler_sequencer_counter.sv
// Tracks the index of the lane-0 symbol inside a 16-symbol 128b/130b block
// and flags the beat that completes the block.
module block_symbol_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       step_en,
  input  logic       clear,
  input  logic [2:0] step,
  output logic [3:0] symbol_index,
  output logic       wrap,
  output logic       block_start
);

  logic [3:0] idx_q, idx_d;
  logic [4:0] sum;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sum   = {1'b0, idx_q} + {2'b00, step};
    wrap  = step_en && sum[4];
    idx_d = idx_q;
    if (clear) begin
      idx_d = '0;
    end else if (step_en) begin
      idx_d = sum[3:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign symbol_index = idx_q;
  assign block_start  = (idx_q == 4'd0);

endmodule

// File: rtl/descrambler_sequencer.sv
// Drives the descrambler LFSR controls (reseed, per-lane advance, per-lane XOR
// enable) from the PIPE RX stream for both 8b/10b and 128b/130b encodings.
module descrambler_sequencer
  import descrambler_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        turnOff,
  input  logic        PIPEDataValid,
  input  logic [1:0]  PIPESyncHeader,
  input  logic [5:0]  PIPEWIDTH,
  input  logic [2:0]  GEN,
  input  logic [31:0] PIPEData,
  input  logic [3:0]  PIPEDataK,
  output logic        patternReset,
  output logic [3:0]  advance,
  output logic [3:0]  descramblingEnable,
  output logic [2:0]  blockType,
  output logic [3:0]  symbolIndex,
  output logic        syncError
);

  blk_state_t  state_q, state_d;
  block_type_t blk_type_q, blk_type_d;
  block_type_t hdr_type, cur_type;
  logic        pattern_reset_q, pattern_reset_d;
  logic        sync_error_q, sync_error_d;
  logic [2:0]  gen_q;
  logic [5:0]  width_q;

  logic [2:0]  step;
  logic [3:0]  active, adv, desc, sym_idx;
  logic        width_ok, gen3, cfg_change, clear, beat, g3_beat, step_en;
  logic        is_start, wrap, cnt_start, com_seen;

  block_symbol_counter u_counter (
    .clk          (clk),
    .reset        (reset),
    .step_en      (step_en),
    .clear        (clear),
    .step         (step),
    .symbol_index (sym_idx),
    .wrap         (wrap),
    .block_start  (cnt_start)
  );

  always_comb begin
    step       = symbols_per_beat(PIPEWIDTH);
    width_ok   = (step != 3'd0);
    active     = 4'((5'd1 << step) - 5'd1);
    gen3       = (GEN >= 3'd3);
    cfg_change = (GEN != gen_q) || (PIPEWIDTH != width_q);
    clear      = cfg_change && width_ok;
    beat       = reset && PIPEDataValid && width_ok;
    g3_beat    = beat && gen3;
    step_en    = g3_beat && !clear;
    // Counter and FSM agree by construction; both must say "start".
    is_start   = (state_q == BLK_START) && cnt_start;
    hdr_type   = classify(PIPESyncHeader, PIPEData[7:0]);
    cur_type   = is_start ? hdr_type : blk_type_q;

    adv      = '0;
    desc     = '0;
    com_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (beat && active[i]) begin
        if (!gen3) begin
          if (PIPEDataK[i]) begin
            if (PIPEData[8*i +: 8] == SYM_COM) begin
              com_seen = 1'b1;
            end else if (PIPEData[8*i +: 8] != SYM_SKP_K) begin
              adv[i] = !turnOff;
            end
          end else begin
            adv[i]  = !turnOff;
            desc[i] = !turnOff;
          end
        end else begin
          case (cur_type)
            DATA: begin
              adv[i]  = 1'b1;
              desc[i] = 1'b1;
            end
            TS: begin
              adv[i]  = 1'b1;
              desc[i] = (i != 0) || (sym_idx != 4'd0);
            end
            OS_OTHER: adv[i] = 1'b1;
            default: ;
          endcase
        end
      end
    end

    blk_type_d = blk_type_q;
    if (step_en && is_start) blk_type_d = hdr_type;

    state_d = state_q;
    if (clear) begin
      state_d = BLK_START;
    end else if (step_en) begin
      state_d = wrap ? BLK_START : IN_BLOCK;
    end

    pattern_reset_d = (beat && !gen3 && com_seen) ||
                      (step_en && wrap && (cur_type == EIEOS));
    sync_error_d    = g3_beat && is_start && (hdr_type == INVALID);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= BLK_START;
      blk_type_q      <= DATA;
      pattern_reset_q <= 1'b0;
      sync_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      blk_type_q      <= blk_type_d;
      pattern_reset_q <= pattern_reset_d;
      sync_error_q    <= sync_error_d;
    end
  end

  // NOTE: configuration shadows are deliberately not reset; they load during reset so the first beat after reset is not mistaken for a config change.
  always_ff @(posedge clk) begin
    gen_q   <= GEN;
    width_q <= PIPEWIDTH;
  end

  assign advance            = adv;
  assign descramblingEnable = desc;
  assign patternReset       = pattern_reset_q;
  assign syncError          = sync_error_q;
  assign symbolIndex        = width_ok ? sym_idx : 4'd0;
  assign blockType          = !width_ok ? DATA : ((g3_beat && is_start) ? hdr_type : blk_type_q);

endmodule

// File: tb/tb_descrambler_sequencer.sv
// Directed bench for descrambler_sequencer: single-beat vector table plus
// multi-beat block sequences for the 128b/130b corner cases.
module tb_descrambler_sequencer;
  import descrambler_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        turnOff = 1'b0;
  logic        PIPEDataValid = 1'b0;
  logic [1:0]  PIPESyncHeader = 2'b00;
  logic [5:0]  PIPEWIDTH = 6'd32;
  logic [2:0]  GEN = 3'd1;
  logic [31:0] PIPEData = '0;
  logic [3:0]  PIPEDataK = '0;
  logic        patternReset;
  logic [3:0]  advance;
  logic [3:0]  descramblingEnable;
  logic [2:0]  blockType;
  logic [3:0]  symbolIndex;
  logic        syncError;

  always #5 clk = ~clk;

  descrambler_sequencer dut (
    .clk                (clk),
    .reset              (reset),
    .turnOff            (turnOff),
    .PIPEDataValid      (PIPEDataValid),
    .PIPESyncHeader     (PIPESyncHeader),
    .PIPEWIDTH          (PIPEWIDTH),
    .GEN                (GEN),
    .PIPEData           (PIPEData),
    .PIPEDataK          (PIPEDataK),
    .patternReset       (patternReset),
    .advance            (advance),
    .descramblingEnable (descramblingEnable),
    .blockType          (blockType),
    .symbolIndex        (symbolIndex),
    .syncError          (syncError)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [2:0]  gen;
    logic [5:0]  width;
    logic        valid;
    logic        toff;
    logic [1:0]  hdr;
    logic [31:0] data;
    logic [3:0]  k;
    logic [3:0]  adv;
    logic [3:0]  desc;
    block_type_t btype;
    logic        pr;
    logic        se;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs[NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0;
    PIPEDataValid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_beat(input logic v, input logic [1:0] h, input logic [31:0] d, input logic [3:0] k);
    PIPEDataValid  = v;
    PIPESyncHeader = h;
    PIPEData       = d;
    PIPEDataK      = k;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           gen   width  v     toff  hdr    data          k        adv      desc     btype     pr    se
    vecs[0]  = '{3'd1, 6'd32, 1'b1, 1'b0, 2'b00, 32'h112233BC, 4'b0001, 4'b1110, 4'b1110, DATA,     1'b1, 1'b0};
    vecs[1]  = '{3'd1, 6'd32, 1'b1, 1'b0, 2'b00, 32'h4455661C, 4'b0001, 4'b1110, 4'b1110, DATA,     1'b0, 1'b0};
    vecs[2]  = '{3'd1, 6'd16, 1'b1, 1'b0, 2'b00, 32'hBCBC1234, 4'b1100, 4'b0011, 4'b0011, DATA,     1'b0, 1'b0};
    vecs[3]  = '{3'd1, 6'd8,  1'b1, 1'b0, 2'b00, 32'hBCBCBCF7, 4'b1111, 4'b0001, 4'b0000, DATA,     1'b0, 1'b0};
    vecs[4]  = '{3'd2, 6'd32, 1'b1, 1'b1, 2'b00, 32'h123456BC, 4'b0001, 4'b0000, 4'b0000, DATA,     1'b1, 1'b0};
    vecs[5]  = '{3'd1, 6'd32, 1'b0, 1'b0, 2'b00, 32'h000000BC, 4'b0001, 4'b0000, 4'b0000, DATA,     1'b0, 1'b0};
    vecs[6]  = '{3'd1, 6'd24, 1'b1, 1'b0, 2'b00, 32'h000000BC, 4'b0001, 4'b0000, 4'b0000, DATA,     1'b0, 1'b0};
    vecs[7]  = '{3'd3, 6'd32, 1'b1, 1'b0, 2'b01, 32'h000000BC, 4'b0001, 4'b1111, 4'b1111, DATA,     1'b0, 1'b0};
    vecs[8]  = '{3'd3, 6'd32, 1'b1, 1'b0, 2'b10, 32'hAAAAAAAA, 4'b0000, 4'b0000, 4'b0000, SKP,      1'b0, 1'b0};
    vecs[9]  = '{3'd3, 6'd32, 1'b1, 1'b0, 2'b10, 32'h66666666, 4'b0000, 4'b0000, 4'b0000, EIOS,     1'b0, 1'b0};
    vecs[10] = '{3'd3, 6'd32, 1'b1, 1'b0, 2'b10, 32'h4A4A4A2D, 4'b0000, 4'b1111, 4'b1110, TS,       1'b0, 1'b0};
    vecs[11] = '{3'd3, 6'd32, 1'b1, 1'b0, 2'b10, 32'h12345655, 4'b0000, 4'b1111, 4'b0000, OS_OTHER, 1'b0, 1'b0};
    vecs[12] = '{3'd3, 6'd8,  1'b1, 1'b0, 2'b00, 32'h00000011, 4'b0000, 4'b0000, 4'b0000, INVALID,  1'b0, 1'b1};
    vecs[13] = '{3'd1, 6'd32, 1'b1, 1'b0, 2'b00, 32'hBCBCBCBC, 4'b1111, 4'b0000, 4'b0000, DATA,     1'b1, 1'b0};
    vecs[14] = '{3'd4, 6'd32, 1'b1, 1'b1, 2'b01, 32'hDEADBEEF, 4'b0000, 4'b1111, 4'b1111, DATA,     1'b0, 1'b0};
    vecs[15] = '{3'd3, 6'd16, 1'b1, 1'b0, 2'b10, 32'h00000000, 4'b0000, 4'b0000, 4'b0000, EIEOS,    1'b0, 1'b0};

    // Reset values
    reset_dut();
    check("reset patternReset", patternReset, 1'b0);
    check("reset syncError", syncError, 1'b0);
    check("reset blockType", blockType, DATA);
    check("reset symbolIndex", symbolIndex, 4'd0);

    // Single-beat table, each from a fresh block start
    for (int i = 0; i < NVEC; i++) begin
      GEN = vecs[i].gen;
      PIPEWIDTH = vecs[i].width;
      turnOff = vecs[i].toff;
      reset_dut();
      @(negedge clk);
      set_beat(vecs[i].valid, vecs[i].hdr, vecs[i].data, vecs[i].k);
      #1;
      check($sformatf("vec%0d advance", i), advance, vecs[i].adv);
      check($sformatf("vec%0d descramblingEnable", i), descramblingEnable, vecs[i].desc);
      check($sformatf("vec%0d blockType", i), blockType, vecs[i].btype);
      @(posedge clk); #1;
      check($sformatf("vec%0d patternReset", i), patternReset, vecs[i].pr);
      check($sformatf("vec%0d syncError", i), syncError, vecs[i].se);
      @(negedge clk);
      PIPEDataValid = 1'b0;
      @(posedge clk); #1;
      check($sformatf("vec%0d patternReset drop", i), patternReset, 1'b0);
      check($sformatf("vec%0d syncError drop", i), syncError, 1'b0);
    end
    turnOff = 1'b0;

    // Gen3 x8 data block: 16 beats, header ignored after the start beat
    GEN = 3'd3; PIPEWIDTH = 6'd8;
    reset_dut();
    for (int b = 0; b < 16; b++) begin
      @(negedge clk);
      set_beat(1'b1, (b == 0) ? 2'b01 : 2'b11, 32'h000000C3 + b, 4'b0000);
      #1;
      check($sformatf("x8 beat%0d advance", b), advance, 4'b0001);
      check($sformatf("x8 beat%0d descramblingEnable", b), descramblingEnable, 4'b0001);
      check($sformatf("x8 beat%0d symbolIndex", b), symbolIndex, b);
      check($sformatf("x8 beat%0d blockType", b), blockType, DATA);
      @(posedge clk); #1;
      check($sformatf("x8 beat%0d syncError", b), syncError, 1'b0);
    end
    @(negedge clk);
    PIPEDataValid = 1'b0;
    #1;
    check("x8 wrap symbolIndex", symbolIndex, 4'd0);

    // Gen3 x32 EIEOS: reseed only after the last beat
    GEN = 3'd3; PIPEWIDTH = 6'd32;
    reset_dut();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      set_beat(1'b1, (b == 0) ? 2'b10 : 2'b01, (b == 0) ? 32'hFFFFFF00 : 32'hFFFFFFFF, 4'b0000);
      #1;
      check($sformatf("eieos beat%0d advance", b), advance, 4'b0000);
      check($sformatf("eieos beat%0d descramblingEnable", b), descramblingEnable, 4'b0000);
      @(posedge clk); #1;
      check($sformatf("eieos beat%0d patternReset", b), patternReset, (b == 3));
    end
    @(negedge clk);
    PIPEDataValid = 1'b0;
    @(posedge clk); #1;
    check("eieos patternReset drop", patternReset, 1'b0);

    // Gen3 x16 TS1: lane-0 symbol 0 is not descrambled
    GEN = 3'd3; PIPEWIDTH = 6'd16;
    reset_dut();
    for (int b = 0; b < 8; b++) begin
      @(negedge clk);
      set_beat(1'b1, (b == 0) ? 2'b10 : 2'b11, (b == 0) ? 32'h00004A1E : 32'h00004A4A, 4'b0000);
      #1;
      check($sformatf("ts1 beat%0d advance", b), advance, 4'b0011);
      check($sformatf("ts1 beat%0d descramblingEnable", b), descramblingEnable, (b == 0) ? 4'b0010 : 4'b0011);
      check($sformatf("ts1 beat%0d symbolIndex", b), symbolIndex, 2 * b);
    end
    @(negedge clk);
    PIPEDataValid = 1'b0;
    #1;
    check("ts1 wrap symbolIndex", symbolIndex, 4'd0);

    // Gen3 x32 invalid header then a normal data block
    GEN = 3'd3; PIPEWIDTH = 6'd32;
    reset_dut();
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      set_beat(1'b1, (b == 0) ? 2'b11 : 2'b01, 32'h12345678, 4'b0000);
      #1;
      check($sformatf("inv beat%0d advance", b), advance, 4'b0000);
      check($sformatf("inv beat%0d descramblingEnable", b), descramblingEnable, 4'b0000);
      check($sformatf("inv beat%0d blockType", b), blockType, INVALID);
      @(posedge clk); #1;
      check($sformatf("inv beat%0d syncError", b), syncError, (b == 0));
    end
    @(negedge clk);
    set_beat(1'b1, 2'b01, 32'h87654321, 4'b0000);
    #1;
    check("post-inv advance", advance, 4'b1111);
    check("post-inv descramblingEnable", descramblingEnable, 4'b1111);
    check("post-inv blockType", blockType, DATA);
    @(posedge clk); #1;
    check("post-inv syncError", syncError, 1'b0);

    // Gen3 x8 reset after beat 5 discards the partial block
    GEN = 3'd3; PIPEWIDTH = 6'd8;
    reset_dut();
    for (int b = 0; b < 5; b++) begin
      @(negedge clk);
      set_beat(1'b1, 2'b01, 32'h0000005A, 4'b0000);
    end
    @(negedge clk);
    reset = 1'b0;
    set_beat(1'b1, 2'b01, 32'h0000005A, 4'b0000);
    #1;
    check("in-reset advance", advance, 4'b0000);
    check("in-reset descramblingEnable", descramblingEnable, 4'b0000);
    @(posedge clk); #1;
    check("mid-reset symbolIndex", symbolIndex, 4'd0);
    check("mid-reset blockType", blockType, DATA);
    check("mid-reset patternReset", patternReset, 1'b0);
    check("mid-reset syncError", syncError, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    set_beat(1'b1, 2'b10, 32'h000000AA, 4'b0000);
    #1;
    check("after-reset blockType", blockType, SKP);
    check("after-reset advance", advance, 4'b0000);

    // Width change mid-block forces a fresh block start
    GEN = 3'd3; PIPEWIDTH = 6'd8;
    reset_dut();
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      set_beat(1'b1, 2'b01, 32'h00000033, 4'b0000);
    end
    @(negedge clk);
    PIPEDataValid = 1'b0;
    PIPEWIDTH = 6'd16;
    @(posedge clk); #1;
    check("cfg-change symbolIndex", symbolIndex, 4'd0);
    @(negedge clk);
    set_beat(1'b1, 2'b10, 32'h000000AA, 4'b0000);
    #1;
    check("cfg-change blockType", blockType, SKP);
    check("cfg-change advance", advance, 4'b0000);
    @(negedge clk);
    PIPEDataValid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/descrambler_sequencer.md
# descrambler_sequencer

Sequential controller that drives the descrambler's LFSR control inputs (`patternReset`, `advance`, `descramblingEnable`) from the received PIPE stream. It sits between the PIPE RX interface and the descrambler datapath. For Gen1/2 (8b/10b) it decodes K-symbols per byte lane. For Gen3+ (128b/130b) it tracks 16-symbol block boundaries and classifies each block as data, SKP, EIEOS, EIOS, TS or invalid. It decides per lane whether the LFSR advances and whether the byte is descrambled.

## Interface
- No parameters; lane count fixed at 4 byte lanes (32-bit datapath).
- `clk` in 1: PIPE clock, all logic rising-edge.
- `reset` in 1: reset is synchronous and active-low.
- `turnOff` in 1: scrambling disabled (honoured for GEN<3 only).
- `PIPEDataValid` in 1: beat qualifier.
- `PIPESyncHeader` in 2: 01 data block, 10 ordered set; sampled on block-start beats only.
- `PIPEWIDTH` in 6: 8/16/32, giving 1/2/4 symbols per beat.
- `GEN` in 3: link generation.
- `PIPEData` in 32: received symbols, lane 0 = [7:0].
- `PIPEDataK` in 4: K flags per lane (GEN<3).
- `patternReset` out 1: LFSR reseed pulse.
- `advance` out 4: per-lane LFSR advance.
- `descramblingEnable` out 4: per-lane XOR enable.
- `blockType` out 3: current Gen3 block class.
- `symbolIndex` out 4: index of lane-0 symbol within current block.
- `syncError` out 1: one-cycle pulse on invalid sync header.

## Operation
- Active lanes are lanes [0 .. PIPEWIDTH/8-1]. Inactive lanes always drive `advance`=0 and `descramblingEnable`=0. For any other PIPEWIDTH value, all outputs are 0 and state is held.
- `PIPEDataValid`=0: `advance`=0, `descramblingEnable`=0, counters hold.
- **GEN<3, per active lane:**
  - K=1 and 0xBC (COM): no advance, no descramble; schedule `patternReset`.
  - K=1 and 0x1C (SKP): no advance, no descramble.
  - Other K: advance, no descramble.
  - K=0: advance and descramble.
  - `turnOff`=1: all outputs 0 except `patternReset` on COM.
- **GEN>=3 block tracking:**
  - FSM states: BLK_START, IN_BLOCK.
  - BLK_START, valid beat: class taken from sync header and lane-0 symbol.
    - 01 → DATA.
    - 10 with 0x00 → EIEOS; 0xAA → SKP; 0x66 → EIOS; 0x1E/0x2D → TS; any other symbol → OS_OTHER.
    - 00/11 → INVALID, and `syncError` pulses.
  - The class is applied combinationally on the start beat and registered for the remaining beats.
  - `symbolIndex` increments by symbols-per-beat on each valid beat. Reaching 16 wraps to 0 and returns the FSM to BLK_START.
- **GEN>=3 per-lane rules** (s = block symbol index of that lane):
  - DATA: advance and descramble.
  - TS: advance always; descramble s≥1.
  - OS_OTHER: advance, no descramble.
  - SKP, EIOS, INVALID: no advance, no descramble.
  - EIEOS: no advance, no descramble; schedule `patternReset` on the last beat of the block.
- `turnOff` is ignored when GEN>=3.
- A change of GEN or PIPEWIDTH forces BLK_START with `symbolIndex`=0 on the next cycle.

## Timing
- `advance` and `descramblingEnable` are combinational from the current beat plus registered state, so the LFSR sees them in the same cycle as the data.
- `patternReset` and `syncError` are registered, one-cycle pulses, asserted the cycle after the triggering beat.
- Multiple COMs in one beat produce a single `patternReset` pulse.
- Reset values: `patternReset`=0, `syncError`=0, `blockType`=DATA, `symbolIndex`=0, FSM=BLK_START. `advance` and `descramblingEnable` are 0 while `reset`=0.
- Reset mid-block discards the partial block; the first valid beat after reset is a block start.
- Invalid header followed by a valid header on the next block start: normal classification resumes with no sticky error.

## Structure
- Package `descrambler_seq_pkg` holds:
  - symbol constants: COM 0xBC, SKP_K 0x1C, EIEOS 0x00, SKP_OS 0xAA, EIOS 0x66, TS1 0x1E, TS2 0x2D;
  - sync header constants;
  - the `block_type_t` enum (DATA, TS, SKP, EIEOS, EIOS, OS_OTHER, INVALID).
- One sub-module, `block_symbol_counter`: symbol index, wrap and block-start flag.

## Test plan
- GEN=1, width 32, K=4'b0001, data {0x11,0x22,0x33,0xBC}:
  - same cycle: `advance`=4'b1110, `descramblingEnable`=4'b1110;
  - next cycle: `patternReset`=1 for exactly one cycle.
- GEN=3, width 8, header 01, 16 valid beats:
  - `advance`=`descramblingEnable`=4'b0001 every beat;
  - `symbolIndex` runs 0..15, then returns to 0.
- GEN=3, width 32, header 10 with lane0=0x00 (EIEOS), 4 beats:
  - `advance`=0 and `descramblingEnable`=0 on every beat;
  - `patternReset`=1 in the cycle after beat 4.
- GEN=3, width 16, TS1 block:
  - beat 0: `advance`=4'b0011, `descramblingEnable`=4'b0010;
  - beats 1–7: both outputs 4'b0011.
- GEN=3, width 32, header 11:
  - `syncError` pulses once; all outputs 0 for 4 beats;
  - next block with header 01 is descrambled normally.
- GEN=3, width 8, `reset` low after beat 5:
  - all outputs return to reset values;
  - the next valid beat is classified as a block start.
